result_writeback: RTL and testbench

Sits directly downstream of the 32-lane bias/LeakyReLU/requantize post-process array. It captures each int8 result vector on the array's single-cycle `done` pulse into a small vector FIFO. It then packs the vector into WORD_BYTES-wide words and streams them to the output feature-map SRAM over a valid/ready write port with an auto-incrementing address. The FIFO absorbs write-port backpressure, because the post-process array cannot stall.

---
 rtl/result_writeback.sv | 167 ++++++++++++++++
 tb/tb_result_writeback.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback.sv
// Buffers post-process result vectors and streams them as packed words to the output SRAM.
// Define WB_STALL_CNT_EN to add the stall_cycles backpressure counter port.
module result_writeback #(
  parameter int LANES      = 32,
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic signed [7:0]       pp_result [0:LANES-1],
  input  logic                    pp_done,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    busy,
  output logic                    overflow,
  output logic [15:0]             vec_count
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int WPV    = LANES / WORD_BYTES;
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDX_W  = (WPV > 1) ? $clog2(WPV) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPV - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic signed [7:0] mem [0:FIFO_DEPTH-1][0:LANES-1];
  logic signed [7:0] src [0:LANES-1];
  state_t            state, state_n;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [IDX_W-1:0]  word_idx, word_idx_n, src_idx;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [WORD_W-1:0] data_n;
  logic [15:0]       vec_count_n;
  logic              overflow_n;
  logic              hs, last, push, pop, full, drop, more, load;
`ifdef WB_STALL_CNT_EN
  logic [31:0]       stall_n;
`endif

  assign wr_valid = (state == SEND);
  assign wr_addr  = addr;
  assign busy     = (count != '0) || wr_valid;

  always_comb begin
    hs       = wr_valid && wr_ready;
    last     = hs && (word_idx == LAST_IDX);
    pop      = last;
    full     = (count == DEPTH_C);
    // A full FIFO still accepts a vector when the head retires in the same cycle.
    push     = pp_done && !start && (!full || pop);
    drop     = pp_done && !start && full && !pop;
    more     = pop ? (count > CNT_W'(1)) : (count != '0);
    rd_ptr_n = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_n = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    count_n  = count;
    if (push && !pop)      count_n = count + CNT_W'(1);
    else if (pop && !push) count_n = count - CNT_W'(1);

    // Next word comes from the current head, the next queued vector, or the incoming bypass.
    src_idx = '0;
    src     = pp_result;
    if (state == SEND && !last) begin
      src     = mem[rd_ptr];
      src_idx = word_idx + IDX_W'(1);
    end else if (more) begin
      src     = mem[rd_ptr_n];
    end
    data_n = '0;
    for (int b = 0; b < WORD_BYTES; b++)
      data_n[8*b +: 8] = src[LANE_W'(int'(src_idx) * WORD_BYTES + b)];

    state_n     = state;
    addr_n      = addr;
    word_idx_n  = word_idx;
    load        = 1'b0;
    vec_count_n = last ? vec_count + 16'd1 : vec_count;
    overflow_n  = overflow || drop;
`ifdef WB_STALL_CNT_EN
    stall_n     = (wr_valid && !wr_ready && stall_cycles != 32'hFFFF_FFFF)
                  ? stall_cycles + 32'd1 : stall_cycles;
`endif
    if (start) begin
      state_n     = IDLE;
      addr_n      = base_addr;
      word_idx_n  = '0;
      rd_ptr_n    = '0;
      wr_ptr_n    = '0;
      count_n     = '0;
      vec_count_n = '0;
      overflow_n  = 1'b0;
`ifdef WB_STALL_CNT_EN
      stall_n     = '0;
`endif
    end else begin
      case (state)
        IDLE: if (count_n != '0) begin
          state_n    = SEND;
          word_idx_n = '0;
          load       = 1'b1;
        end
        SEND: if (hs) begin
          addr_n = addr + ADDR_W'(1);
          load   = 1'b1;
          if (last) begin
            word_idx_n = '0;
            if (count_n == '0) begin
              state_n = IDLE;
              load    = 1'b0;
            end
          end else begin
            word_idx_n = word_idx + IDX_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      word_idx  <= '0;
      addr      <= '0;
      wr_data   <= '0;
      vec_count <= '0;
      overflow  <= 1'b0;
`ifdef WB_STALL_CNT_EN
      stall_cycles <= '0;
`endif
    end else begin
      state     <= state_n;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      count     <= count_n;
      word_idx  <= word_idx_n;
      addr      <= addr_n;
      vec_count <= vec_count_n;
      overflow  <= overflow_n;
      if (load) wr_data <= data_n;
`ifdef WB_STALL_CNT_EN
      stall_cycles <= stall_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pp_result;
  end

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: table-driven single vector plus multi-cycle corner sequences.
module tb_result_writeback;

  logic              clk = 1'b0;
  logic              rst_n, start, pp_done, wr_ready;
  logic [15:0]       base_addr;
  logic signed [7:0] pp_result [0:31];
  logic              wr_valid, busy, overflow;
  logic [15:0]       wr_addr, vec_count;
  logic [31:0]       wr_data;
`ifdef WB_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int stalls = 0;
  logic [15:0] exp_addr;
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;

  result_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .pp_result(pp_result), .pp_done(pp_done), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .overflow(overflow), .vec_count(vec_count)
`ifdef WB_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic        done;
    logic        rdy;
    logic        vld;
    logic [15:0] addr;
    logic [31:0] data;
    logic        bsy;
    logic [15:0] vc;
  } row_t;
  row_t tbl [0:8];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int base);
    for (int i = 0; i < 32; i++) pp_result[i] = 8'(base + i);
  endtask

  task automatic expect_vec(input int base);
    logic [31:0] d;
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 4; b++) d[8*b +: 8] = 8'(base + 4*w + b);
      exp_q.push_back({exp_addr, d});
      exp_addr = exp_addr + 16'd1;
    end
  endtask

  // One clock: drive inputs, check any handshake against the expected write queue.
  task automatic cyc(input logic done, input logic rdy);
    logic [47:0] e;
    pp_done  = done;
    wr_ready = rdy;
    if (wr_valid && !wr_ready) stalls++;
    if (wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got %h expected none", {wr_addr, wr_data});
      end else begin
        e = exp_q.pop_front();
        chk("write", {wr_addr, wr_data}, e);
      end
    end
    @(posedge clk);
    #1;
    pp_done = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] base, input logic done);
    start     = 1'b1;
    base_addr = base;
    pp_done   = done;
    @(posedge clk);
    #1;
    start    = 1'b0;
    pp_done  = 1'b0;
    exp_addr = base;
    exp_q.delete();
    stalls   = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      cyc(1'b0, 1'b1);
      n++;
    end
    chk("drain_words_left", 48'(exp_q.size()), 48'd0);
    chk("drain_busy", 48'(busy), 48'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic d;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 16'h0100, 32'hF3F2F1F0, 1'b1, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h0101, 32'hF7F6F5F4, 1'b1, 16'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h0102, 32'hFBFAF9F8, 1'b1, 16'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0103, 32'hFFFEFDFC, 1'b1, 16'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 16'h0104, 32'h03020100, 1'b1, 16'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h0105, 32'h07060504, 1'b1, 16'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 16'h0106, 32'h0B0A0908, 1'b1, 16'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 16'h0107, 32'h0F0E0D0C, 1'b1, 16'd0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 16'h0108, 32'h00000000, 1'b0, 16'd1};

    rst_n = 1'b0; start = 1'b0; pp_done = 1'b0; wr_ready = 1'b0;
    base_addr = 16'h0; exp_addr = 16'h0;
    set_vec(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_valid", 48'(wr_valid), 48'd0);
    chk("rst_wr_addr", 48'(wr_addr), 48'd0);
    chk("rst_wr_data", 48'(wr_data), 48'd0);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_overflow", 48'(overflow), 48'd0);
    chk("rst_vec_count", 48'(vec_count), 48'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single vector, lane i = i-16, cycle by cycle from the table.
    do_start(16'h0100, 1'b0);
    set_vec(-16);
    for (int i = 0; i < 9; i++) begin
      pp_done  = tbl[i].done;
      wr_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      pp_done = 1'b0;
      chk($sformatf("t1_valid_%0d", i), 48'(wr_valid), 48'(tbl[i].vld));
      chk($sformatf("t1_addr_%0d", i), 48'(wr_addr), 48'(tbl[i].addr));
      if (tbl[i].vld) chk($sformatf("t1_data_%0d", i), 48'(wr_data), 48'(tbl[i].data));
      chk($sformatf("t1_busy_%0d", i), 48'(busy), 48'(tbl[i].bsy));
      chk($sformatf("t1_vcnt_%0d", i), 48'(vec_count), 48'(tbl[i].vc));
    end

    // Backpressure: ready pattern 1,0,0 repeating, three vectors two cycles apart.
    do_start(16'h0400, 1'b0);
    p = 0;
    while ((p < 5 || busy) && p < 400) begin
      d = (p == 0 || p == 2 || p == 4);
      if (d) begin
        set_vec(p * 10 + 1);
        expect_vec(p * 10 + 1);
      end
      cyc(d, (p % 3) == 0);
      p++;
    end
    chk("t2_words_left", 48'(exp_q.size()), 48'd0);
    chk("t2_overflow", 48'(overflow), 48'd0);
    chk("t2_vec_count", 48'(vec_count), 48'd3);
`ifdef WB_STALL_CNT_EN
    chk("t2_stall_cycles", 48'(stall_cycles), 48'(stalls));
`endif

    // Overflow: five pushes into a four-deep FIFO with the port stalled.
    do_start(16'h0800, 1'b0);
    for (int k = 0; k < 5; k++) begin
      set_vec(k * 33 + 7);
      if (k < 4) expect_vec(k * 33 + 7);
      cyc(1'b1, 1'b0);
      chk($sformatf("t3_overflow_%0d", k), 48'(overflow), 48'(k == 4));
    end
    drain();
    chk("t3_vec_count", 48'(vec_count), 48'd4);
    chk("t3_overflow_sticky", 48'(overflow), 48'd1);

    // Full FIFO with a push landing on the head's last-word handshake.
    do_start(16'h0900, 1'b0);
    chk("t4_overflow_cleared", 48'(overflow), 48'd0);
    chk("t4_vec_count_cleared", 48'(vec_count), 48'd0);
    for (int k = 0; k < 4; k++) begin
      set_vec(k * 19 + 100);
      expect_vec(k * 19 + 100);
      cyc(1'b1, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        set_vec(200);
        expect_vec(200);
      end
      cyc(k == 7, 1'b1);
    end
    chk("t4_overflow", 48'(overflow), 48'd0);
    chk("t4_vec_count_mid", 48'(vec_count), 48'd1);
    chk("t4_words_queued", 48'(exp_q.size()), 48'd32);
    drain();
    chk("t4_vec_count", 48'(vec_count), 48'd5);

    // Address wrap.
    do_start(16'hFFFC, 1'b0);
    set_vec(50);
    expect_vec(50);
    cyc(1'b1, 1'b1);
    drain();
    chk("t5_addr_after", 48'(wr_addr), 48'h0004);

    // Abort mid-vector, with a pp_done coinciding with start.
    do_start(16'h0300, 1'b0);
    set_vec(90);
    expect_vec(90);
    cyc(1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b1);
    chk("t6_valid_before", 48'(wr_valid), 48'd1);
    chk("t6_addr_before", 48'(wr_addr), 48'h0304);
    wr_ready = 1'b0;
    set_vec(120);
    do_start(16'h0200, 1'b1);
    chk("t6_valid", 48'(wr_valid), 48'd0);
    chk("t6_busy", 48'(busy), 48'd0);
    chk("t6_overflow", 48'(overflow), 48'd0);
    chk("t6_vec_count", 48'(vec_count), 48'd0);
    chk("t6_addr", 48'(wr_addr), 48'h0200);
    set_vec(60);
    expect_vec(60);
    cyc(1'b1, 1'b1);
    drain();
    chk("t6_vec_count_after", 48'(vec_count), 48'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
